// File: rtl/gcd_feeder.sv
// Operand FIFO and launch/capture sequencer in front of the subtractive GCD unit.
// Optional watchdog on the WAIT state is enabled by defining GCD_FEEDER_WDOG_EN.
module gcd_feeder #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_a_i,
    input  logic [W-1:0] in_b_i,
    output logic         gcd_start_o,
    input  logic         gcd_ready_i,
    output logic [W-1:0] gcd_ina_o,
    output logic [W-1:0] gcd_inb_o,
    input  logic [W-1:0] gcd_out_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] res_data_o,
    output logic         res_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mem_a_q [DEPTH];
    logic [W-1:0]   mem_b_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           push_s, pop_s, empty_s, head_zero_s;
    logic [W-1:0]   head_a_s, head_b_s;

`ifdef GCD_FEEDER_WDOG_EN
    localparam logic [W+2:0] WDOG_LIMIT = {3'b100, {W{1'b0}}};
    logic [W+2:0]   wdog_q, wdog_d;
    logic           res_err_q, res_err_d;
`endif

    assign in_ready_o  = (count_q != FULL);
    assign push_s      = in_valid_i && in_ready_o;
    assign empty_s     = (count_q == {CW{1'b0}});
    assign head_a_s    = mem_a_q[rd_ptr_q];
    assign head_b_s    = mem_b_q[rd_ptr_q];
    assign head_zero_s = (head_a_s == {W{1'b0}}) || (head_b_s == {W{1'b0}});
    assign count_d     = count_q + CW'(push_s) - CW'(pop_s);

    assign gcd_ina_o   = head_a_s;
    assign gcd_inb_o   = head_b_s;
    assign res_valid_o = (state_q == HOLD);
    assign res_data_o  = res_data_q;
`ifdef GCD_FEEDER_WDOG_EN
    assign res_err_o   = res_err_q;
`else
    assign res_err_o   = 1'b0;
`endif

    // FIFO storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_a_q[wr_ptr_q] <= in_a_i;
            mem_b_q[wr_ptr_q] <= in_b_i;
        end
    end

    // Pointer, occupancy, FSM and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            res_data_q <= {W{1'b0}};
`ifdef GCD_FEEDER_WDOG_EN
            res_err_q  <= 1'b0;
            wdog_q     <= {(W+3){1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            res_data_q <= res_data_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
`ifdef GCD_FEEDER_WDOG_EN
            res_err_q  <= res_err_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    // Launch / capture sequencing; the FIFO head is popped only when its result is captured
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        gcd_start_o = 1'b0;
        res_data_d  = res_data_q;
`ifdef GCD_FEEDER_WDOG_EN
        res_err_d   = res_err_q;
        wdog_d      = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (empty_s) begin
                    state_d = IDLE;
                end else if (head_zero_s) begin
                    // The unit never terminates on a zero operand; gcd(0,x) = x
                    res_data_d = head_a_s | head_b_s;
`ifdef GCD_FEEDER_WDOG_EN
                    res_err_d  = 1'b0;
`endif
                    pop_s      = 1'b1;
                    state_d    = HOLD;
                end else if (gcd_ready_i) begin
                    gcd_start_o = 1'b1;
                    state_d     = WAIT;
`ifdef GCD_FEEDER_WDOG_EN
                    wdog_d      = {(W+3){1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (gcd_ready_i) begin
                    res_data_d = gcd_out_i;
`ifdef GCD_FEEDER_WDOG_EN
                    res_err_d  = 1'b0;
`endif
                    pop_s      = 1'b1;
                    state_d    = HOLD;
                end else begin
`ifdef GCD_FEEDER_WDOG_EN
                    if (wdog_q == WDOG_LIMIT) begin
                        res_data_d = {W{1'b0}};
                        res_err_d  = 1'b1;
                        pop_s      = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        wdog_d  = wdog_q + (W+3)'(1'b1);
                        state_d = WAIT;
                    end
`else
                    state_d = WAIT;
`endif
                end
            end
            HOLD: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_feeder.sv
// Bench for gcd_feeder: behavioural subtractive GCD unit, directed timing cases and a
// randomized scoreboard run. Watchdog case is built only with GCD_FEEDER_WDOG_EN.
module tb_gcd_feeder;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] in_a_i = '0;
    logic [W-1:0] in_b_i = '0;
    logic         gcd_start_o;
    logic         gcd_ready_i = 1'b1;
    logic [W-1:0] gcd_ina_o, gcd_inb_o;
    logic [W-1:0] gcd_out_i = '0;
    logic         res_valid_o;
    logic         res_ready_i = 1'b1;
    logic [W-1:0] res_data_o;
    logic         res_err_o;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;

    logic         u_busy = 1'b0;
    logic         u_stuck = 1'b0;
    int           u_cnt = 0;
    logic [W-1:0] u_res = '0;

    pair_t exp_q[$];

    gcd_feeder #(.W(W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i),
        .gcd_start_o(gcd_start_o), .gcd_ready_i(gcd_ready_i),
        .gcd_ina_o(gcd_ina_o), .gcd_inb_o(gcd_inb_o), .gcd_out_i(gcd_out_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_err_o(res_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x[W-1:0];
    endfunction

    function automatic int sub_steps(input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, s;
        x = a; y = b; s = 0;
        if (x == 0 || y == 0) return 0;
        while (x != y) begin
            if (x > y) x = x - y; else y = y - x;
            s++;
        end
        return s;
    endfunction

    // Subtractive GCD unit model: one busy cycle per subtraction plus one for the final compare
    always @(posedge clk_i) begin
        if (gcd_start_o) start_cnt <= start_cnt + 1;
        if (u_busy) begin
            if (!u_stuck) begin
                if (u_cnt <= 1) begin
                    u_busy      <= 1'b0;
                    gcd_ready_i <= 1'b1;
                    gcd_out_i   <= u_res;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end
        end else if (gcd_start_o && gcd_ready_i) begin
            u_busy      <= 1'b1;
            gcd_ready_i <= 1'b0;
            u_res       <= ref_gcd(gcd_ina_o, gcd_inb_o);
            u_cnt       <= sub_steps(gcd_ina_o, gcd_inb_o) + 1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag);
        for (int c = 0; c < 3000 && !res_valid_o; c++) tick();
        check({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
    endtask

    task automatic run_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int s0;
        s0 = start_cnt;
        in_valid_i = 1'b1; in_a_i = a; in_b_i = b;
        tick();
        in_valid_i = 1'b0;
        wait_result(tag);
        check({tag, "_data"}, {24'd0, res_data_o}, {24'd0, ref_gcd(a, b)});
        check({tag, "_err"}, {31'd0, res_err_o}, 32'd0);
        tick();
        check({tag, "_starts"}, start_cnt - s0, (a != 0 && b != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic rand_step(input bit drain);
        pair_t p;
        if (drain) begin
            in_valid_i  = 1'b0;
            res_ready_i = 1'b1;
        end else begin
            in_valid_i  = ($urandom_range(0, 2) == 0);
            in_a_i      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 63));
            in_b_i      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 63));
            res_ready_i = ($urandom_range(0, 3) != 0);
        end
        if (gcd_start_o) begin
            if (exp_q.size() == 0) begin
                check("launch_on_empty", {31'd0, gcd_start_o}, 32'd0);
            end else begin
                check("launch_a", {24'd0, gcd_ina_o}, {24'd0, exp_q[0].a});
                check("launch_b", {24'd0, gcd_inb_o}, {24'd0, exp_q[0].b});
            end
        end
        if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", {31'd0, res_valid_o}, 32'd0);
            end else begin
                p = exp_q.pop_front();
                check("rand_data", {24'd0, res_data_o}, {24'd0, ref_gcd(p.a, p.b)});
                check("rand_err", {31'd0, res_err_o}, 32'd0);
            end
        end
        if (in_valid_i && in_ready_o) exp_q.push_back({in_a_i, in_b_i});
        tick();
    endtask

    initial begin
        int s0, idx;
        int bp_a[5] = '{9, 10, 7, 8, 15};
        int bp_b[5] = '{6, 4, 7, 2, 5};
        int bp_r[5] = '{3, 2, 7, 2, 5};

        // Reset state
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_start", {31'd0, gcd_start_o}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_res_data", {24'd0, res_data_o}, 32'd0);
        check("rst_res_err", {31'd0, res_err_o}, 32'd0);

        // (12,12): start in cycle 1, result in cycle 4
        s0 = start_cnt;
        in_valid_i = 1'b1; in_a_i = 8'd12; in_b_i = 8'd12;
        tick();
        in_valid_i = 1'b0;
        check("eq_start_c1", {31'd0, gcd_start_o}, 32'd1);
        check("eq_ina_c1", {24'd0, gcd_ina_o}, 32'd12);
        tick();
        check("eq_unit_busy_c2", {31'd0, gcd_ready_i}, 32'd0);
        check("eq_start_c2", {31'd0, gcd_start_o}, 32'd0);
        tick();
        check("eq_valid_c3", {31'd0, res_valid_o}, 32'd0);
        tick();
        check("eq_valid_c4", {31'd0, res_valid_o}, 32'd1);
        check("eq_data_c4", {24'd0, res_data_o}, 32'd12);
        tick();
        check("eq_valid_c5", {31'd0, res_valid_o}, 32'd0);
        check("eq_starts", start_cnt - s0, 32'd1);

        run_pair("p48_18", 8'd48, 8'd18);

        // Zero operands bypass the unit, result in cycle 2
        s0 = start_cnt;
        in_valid_i = 1'b1; in_a_i = 8'd0; in_b_i = 8'd7;
        tick();
        in_valid_i = 1'b0;
        check("z07_start_c1", {31'd0, gcd_start_o}, 32'd0);
        check("z07_valid_c1", {31'd0, res_valid_o}, 32'd0);
        tick();
        check("z07_valid_c2", {31'd0, res_valid_o}, 32'd1);
        check("z07_data_c2", {24'd0, res_data_o}, 32'd7);
        tick();
        run_pair("z00", 8'd0, 8'd0);
        check("zero_starts", start_cnt - s0, 32'd0);

        // Backpressure: five pairs with the consumer stalled
        res_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_a_i = 8'(bp_a[k]); in_b_i = 8'(bp_b[k]);
            tick();
        end
        check("bp_full_c4", {31'd0, in_ready_o}, 32'd0);
        in_a_i = 8'(bp_a[4]); in_b_i = 8'(bp_b[4]);
        tick();
        check("bp_full_c5", {31'd0, in_ready_o}, 32'd0);
        tick();
        check("bp_ready_after_pop", {31'd0, in_ready_o}, 32'd1);
        check("bp_first_held", {31'd0, res_valid_o}, 32'd1);
        check("bp_first_data", {24'd0, res_data_o}, 32'd3);
        tick();
        in_valid_i  = 1'b0;
        res_ready_i = 1'b1;
        idx = 0;
        for (int c = 0; c < 3000 && idx < 5; c++) begin
            if (res_valid_o) begin
                check($sformatf("bp_res%0d", idx), {24'd0, res_data_o}, 32'(bp_r[idx]));
                idx++;
            end
            tick();
        end
        check("bp_count", idx, 32'd5);

        // Randomized traffic against the scoreboard, then drain
        for (int i = 0; i < 1500; i++) rand_step(1'b0);
        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) rand_step(1'b1);
        check("drain_empty", exp_q.size(), 32'd0);
        for (int c = 0; c < 400 && !gcd_ready_i; c++) tick();

        // Reset while (255,1) is in flight; the unit keeps running
        s0 = start_cnt;
        in_valid_i = 1'b1; in_a_i = 8'd255; in_b_i = 8'd1;
        tick();
        in_valid_i = 1'b0;
        check("mid_start", {31'd0, gcd_start_o}, 32'd1);
        tick(); tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("mid_rst_valid", {31'd0, res_valid_o}, 32'd0);
        check("mid_rst_data", {24'd0, res_data_o}, 32'd0);
        check("mid_rst_err", {31'd0, res_err_o}, 32'd0);
        check("mid_rst_start", {31'd0, gcd_start_o}, 32'd0);
        in_valid_i = 1'b1; in_a_i = 8'd6; in_b_i = 8'd4;
        tick();
        in_valid_i = 1'b0;
        for (int c = 0; c < 3000 && !res_valid_o; c++) begin
            if (gcd_start_o && !gcd_ready_i) check("mid_launch_busy", {31'd0, gcd_start_o}, 32'd0);
            tick();
        end
        check("mid_valid", {31'd0, res_valid_o}, 32'd1);
        check("mid_data", {24'd0, res_data_o}, 32'd2);
        tick();
        check("mid_starts", start_cnt - s0, 32'd2);

`ifdef GCD_FEEDER_WDOG_EN
        // Unit hangs after start: watchdog aborts with res_err
        u_stuck = 1'b1;
        in_valid_i = 1'b1; in_a_i = 8'd5; in_b_i = 8'd3;
        tick();
        in_valid_i = 1'b0;
        check("wd_start", {31'd0, gcd_start_o}, 32'd1);
        idx = 0;
        for (int c = 0; c < 3000 && !res_valid_o; c++) begin
            tick();
            idx++;
        end
        check("wd_valid", {31'd0, res_valid_o}, 32'd1);
        check("wd_cycles", idx, 32'd1026);
        check("wd_data", {24'd0, res_data_o}, 32'd0);
        check("wd_err", {31'd0, res_err_o}, 32'd1);
        tick();
        u_stuck = 1'b0;
        for (int c = 0; c < 100 && !gcd_ready_i; c++) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
